// File: rtl/bm_expr_vector_driver_if.sv
// Operand/response bundle between the expression vector driver and its user.
// The driver takes the slave side; the bench or expression DUT wrapper takes the master side.
interface bm_expr_vector_driver_if #(
    parameter int BITS = 32
);
    logic            start;
    logic            seed_load;
    logic [BITS-1:0] seed_in;
    logic [BITS-1:0] resp_in;
    logic [BITS-1:0] number_in_1_o;
    logic [BITS-1:0] number_in_2_o;
    logic [BITS-2:0] number_in_3_o;
    logic [BITS-1:0] land_1_o;
    logic [BITS-1:0] lor_1_o;
    logic            land_2_o;
    logic            lor_2_o;
    logic            vec_valid;
    logic            busy;
    logic            done;
    logic [15:0]     vec_count;
    logic [BITS-1:0] signature;

    modport master (
        output start, seed_load, seed_in, resp_in,
        input  number_in_1_o, number_in_2_o, number_in_3_o, land_1_o, lor_1_o,
               land_2_o, lor_2_o, vec_valid, busy, done, vec_count, signature
    );

    modport slave (
        input  start, seed_load, seed_in, resp_in,
        output number_in_1_o, number_in_2_o, number_in_3_o, land_1_o, lor_1_o,
               land_2_o, lor_2_o, vec_valid, busy, done, vec_count, signature
    );
endinterface

// File: rtl/bm_expr_vector_driver.sv
// Galois-LFSR operand generator plus MISR response compactor for the expression benchmarks.
// One accepted start issues NUM_VECTORS back-to-back vectors and folds LAT-delayed responses.
module bm_expr_vector_driver #(
    parameter int              BITS        = 32,
    parameter int              NUM_VECTORS = 256,
    parameter int              LAT         = 1,
    parameter logic [BITS-1:0] POLY        = BITS'(32'h80200003),
    parameter logic [BITS-1:0] SEED        = BITS'(32'h00000001)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    bm_expr_vector_driver_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [BITS-2:0] c;
        logic [BITS-1:0] land1;
        logic [BITS-1:0] lor1;
        logic            land2;
        logic            lor2;
    } vec_t;

    localparam int         HB         = BITS / 2;
    localparam int         PD         = (LAT > 0) ? LAT : 1;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_VECTORS - 1);
    localparam logic [2:0] DRAIN_LAST = 3'((LAT > 0) ? LAT - 1 : 0);

    state_t          state_q, state_d;
    logic [BITS-1:0] lfsr_q, lfsr_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [BITS-1:0] sig_q, sig_d;
    logic [2:0]      drain_q, drain_d;
    logic            vld_q, vld_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PD-1:0]   vld_pipe_q, vld_pipe_d;
    vec_t            vec_q, vec_d;
    logic            cap_vld;
    logic [BITS-1:0] seed_eff;

    function automatic logic [BITS-1:0] lfsr_step(input logic [BITS-1:0] x);
        return (x >> 1) ^ (x[0] ? POLY : '0);
    endfunction

    // Odd vectors copy land_1 onto lor_1 so the DUT sees equal operands half the time.
    function automatic vec_t mk_vec(input logic [BITS-1:0] l, input logic odd);
        vec_t v;
        v.a     = l;
        v.b     = {l[HB-1:0], l[BITS-1:HB]};
        v.c     = ~l[BITS-2:0];
        v.land1 = v.b;
        v.lor1  = odd ? v.b : l;
        v.land2 = l[0];
        v.lor2  = l[1];
        return v;
    endfunction

    generate
        if (LAT == 0) begin : g_cap0
            assign cap_vld = vld_q;
        end else begin : g_capn
            assign cap_vld = vld_pipe_q[PD-1];
        end
    endgenerate

    assign seed_eff = !bus.seed_load ? SEED : ((bus.seed_in == '0) ? BITS'(1) : bus.seed_in);

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        sig_d      = sig_q;
        drain_d    = drain_q;
        vld_d      = 1'b0;
        vec_d      = '0;
        vld_pipe_d = PD'({vld_pipe_q, vld_q});

        if (cap_vld && busy_q)
            sig_d = {sig_q[BITS-2:0], 1'b0} ^ (sig_q[BITS-1] ? POLY : '0) ^ bus.resp_in;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = DRIVE;
                    lfsr_d  = seed_eff;
                    cnt_d   = '0;
                    sig_d   = '0;
                    vld_d   = 1'b1;
                end
            end
            DRIVE: begin
                // vector cnt_q is on the outputs this cycle; prepare the next one
                cnt_d  = 16'(cnt_q + 16'd1);
                lfsr_d = lfsr_step(lfsr_q);
                if (cnt_q == LAST_IDX) begin
                    state_d = (LAT == 0) ? DONE : DRAIN;
                    drain_d = '0;
                end else begin
                    vld_d = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = DONE;
                else                       drain_d = 3'(drain_q + 3'd1);
            end
            default: state_d = IDLE;
        endcase

        if (vld_d) vec_d = mk_vec(lfsr_d, cnt_d[0]);
        busy_d = (state_d == DRIVE) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            cnt_q      <= '0;
            sig_q      <= '0;
            drain_q    <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_pipe_q <= '0;
            vec_q      <= '0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            sig_q      <= sig_d;
            drain_q    <= drain_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            vld_pipe_q <= vld_pipe_d;
            vec_q      <= vec_d;
        end
    end

    assign bus.number_in_1_o = vec_q.a;
    assign bus.number_in_2_o = vec_q.b;
    assign bus.number_in_3_o = vec_q.c;
    assign bus.land_1_o      = vec_q.land1;
    assign bus.lor_1_o       = vec_q.lor1;
    assign bus.land_2_o      = vec_q.land2;
    assign bus.lor_2_o       = vec_q.lor2;
    assign bus.vec_valid     = vld_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.vec_count     = cnt_q;
    assign bus.signature     = sig_q;
endmodule

// File: tb/tb_bm_expr_vector_driver.sv
// Directed bench for bm_expr_vector_driver: 4-vector runs, LAT=1, hand-computed LFSR/MISR values.
module tb_bm_expr_vector_driver;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;

  bm_expr_vector_driver_if #(.BITS(32)) bus();

  bm_expr_vector_driver #(.BITS(32), .NUM_VECTORS(4), .LAT(1)) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  always #5 clock = ~clock;

  // Start is accepted on the next rising edge; returns 1ns into cycle T+1.
  task automatic kick(input logic ld, input logic [31:0] s);
    @(negedge clock);
    bus.start = 1'b1; bus.seed_load = ld; bus.seed_in = s;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.seed_load = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 12) begin @(posedge clock); #1; n++; end
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL %s_timeout: done=%b want 1", tag, bus.done); end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.vec_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.vec_valid); end
    checks++; if (bus.number_in_1_o !== 32'h0) begin errors++; $display("FAIL rst_a: got %h want 0", bus.number_in_1_o); end
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b want 00", bus.busy, bus.done); end
    checks++; if (bus.vec_count !== 16'h0 || bus.signature !== 32'h0) begin errors++; $display("FAIL rst_cnt_sig: got %h %h want 0 0", bus.vec_count, bus.signature); end
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(negedge clock);
    checks++; if (bus.vec_valid !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL idle_quiet: valid=%b busy=%b want 0 0", bus.vec_valid, bus.busy); end
  endtask

  task automatic test_seed();
    kick(1'b1, 32'h1);
    #3;
    checks++; if (bus.vec_valid !== 1'b1) begin errors++; $display("FAIL v0_valid: got %b want 1", bus.vec_valid); end
    checks++; if (bus.number_in_1_o !== 32'h00000001) begin errors++; $display("FAIL v0_a: got %h want 00000001", bus.number_in_1_o); end
    checks++; if (bus.number_in_2_o !== 32'h00010000) begin errors++; $display("FAIL v0_b: got %h want 00010000", bus.number_in_2_o); end
    checks++; if (bus.number_in_3_o !== 31'h7FFFFFFE) begin errors++; $display("FAIL v0_c: got %h want 7ffffffe", bus.number_in_3_o); end
    checks++; if (bus.land_2_o !== 1'b1 || bus.lor_2_o !== 1'b0) begin errors++; $display("FAIL v0_bits: got %b%b want 10", bus.land_2_o, bus.lor_2_o); end
    checks++; if (bus.lor_1_o !== 32'h1 || bus.land_1_o !== 32'h00010000) begin errors++; $display("FAIL v0_lor_land: got %h %h want 00000001 00010000", bus.lor_1_o, bus.land_1_o); end
    checks++; if (bus.vec_count !== 16'd0 || bus.busy !== 1'b1) begin errors++; $display("FAIL v0_cnt_busy: got %0d %b want 0 1", bus.vec_count, bus.busy); end
    @(posedge clock); #4;
    checks++; if (bus.number_in_1_o !== 32'h80200003) begin errors++; $display("FAIL v1_a: got %h want 80200003", bus.number_in_1_o); end
    checks++; if (bus.lor_1_o !== 32'h00038020 || bus.land_1_o !== 32'h00038020) begin errors++; $display("FAIL v1_lor_eq_land: got %h %h want 00038020 00038020", bus.lor_1_o, bus.land_1_o); end
    @(posedge clock); #4;
    checks++; if (bus.number_in_1_o !== 32'hC0300002 || bus.lor_1_o !== 32'hC0300002) begin errors++; $display("FAIL v2_a_lor: got %h %h want c0300002 c0300002", bus.number_in_1_o, bus.lor_1_o); end
    wait_done("seed");
    checks++; if (bus.vec_count !== 16'd4 || bus.number_in_1_o !== 32'h0) begin errors++; $display("FAIL seed_end: cnt=%0d a=%h want 4 0", bus.vec_count, bus.number_in_1_o); end
  endtask

  task automatic test_seed_select();
    kick(1'b1, 32'h0); #3;
    checks++; if (bus.number_in_1_o !== 32'h00000001) begin errors++; $display("FAIL zero_seed: got %h want 00000001", bus.number_in_1_o); end
    wait_done("zero_seed");
    kick(1'b0, 32'h12345678); #3;
    checks++; if (bus.number_in_1_o !== 32'h00000001) begin errors++; $display("FAIL default_seed: got %h want 00000001", bus.number_in_1_o); end
    wait_done("default_seed");
    kick(1'b1, 32'h12345678); #3;
    checks++; if (bus.number_in_1_o !== 32'h12345678) begin errors++; $display("FAIL load_seed_a: got %h want 12345678", bus.number_in_1_o); end
    checks++; if (bus.number_in_2_o !== 32'h56781234) begin errors++; $display("FAIL load_seed_b: got %h want 56781234", bus.number_in_2_o); end
    checks++; if (bus.number_in_3_o !== 31'h6DCBA987) begin errors++; $display("FAIL load_seed_c: got %h want 6dcba987", bus.number_in_3_o); end
    wait_done("load_seed");
  endtask

  // Full run timeline; resp_first is applied in the first capture cycle (T+2), 0 otherwise.
  // A start with a new seed is also held during T+2 and must be ignored.
  task automatic test_signature(input string tag, input logic [31:0] resp_first, input logic [31:0] sig_exp);
    kick(1'b1, 32'h1);
    for (int c = 1; c <= 6; c++) begin
      bus.resp_in = (c == 2) ? resp_first : 32'h0;
      bus.start = (c == 2); bus.seed_load = (c == 2); bus.seed_in = 32'hDEAD0000;
      #3;
      checks++; if (bus.vec_valid !== (c <= 4)) begin errors++; $display("FAIL %s_valid_c%0d: got %b want %b", tag, c, bus.vec_valid, (c <= 4)); end
      checks++; if (bus.done !== (c == 6)) begin errors++; $display("FAIL %s_done_c%0d: got %b want %b", tag, c, bus.done, (c == 6)); end
      checks++; if (bus.busy !== (c <= 5)) begin errors++; $display("FAIL %s_busy_c%0d: got %b want %b", tag, c, bus.busy, (c <= 5)); end
      if (c == 1) begin
        checks++; if (bus.done !== 1'b0 || bus.signature !== 32'h0) begin errors++; $display("FAIL %s_restart_clear: done=%b sig=%h want 0 0", tag, bus.done, bus.signature); end
      end
      if (c == 3) begin
        checks++; if (bus.number_in_1_o !== 32'hC0300002 || bus.vec_count !== 16'd2) begin errors++; $display("FAIL %s_start_in_drive: a=%h cnt=%0d want c0300002 2", tag, bus.number_in_1_o, bus.vec_count); end
      end
      @(posedge clock); #1;
    end
    bus.start = 1'b0; bus.seed_load = 1'b0;
    checks++; if (bus.vec_count !== 16'd4) begin errors++; $display("FAIL %s_count: got %0d want 4", tag, bus.vec_count); end
    checks++; if (bus.signature !== sig_exp) begin errors++; $display("FAIL %s_sig: got %h want %h", tag, bus.signature, sig_exp); end
    bus.resp_in = 32'hFFFFFFFF;
    repeat (2) @(posedge clock); #1;
    checks++; if (bus.signature !== sig_exp || bus.done !== 1'b1) begin errors++; $display("FAIL %s_hold_in_done: sig=%h done=%b want %h 1", tag, bus.signature, bus.done, sig_exp); end
    bus.resp_in = 32'h0;
  endtask

  task automatic test_reset_mid_run();
    kick(1'b1, 32'h1);
    bus.resp_in = 32'h0;
    @(posedge clock); #1;
    bus.resp_in = 32'h5;
    @(posedge clock); #1;
    bus.resp_in = 32'h0;
    checks++; if (bus.signature !== 32'h5) begin errors++; $display("FAIL mid_sig_pre: got %h want 00000005", bus.signature); end
    #2; reset_n = 1'b0; #1;
    checks++; if (bus.vec_valid !== 1'b0 || bus.number_in_1_o !== 32'h0 || bus.lor_1_o !== 32'h0) begin errors++; $display("FAIL mid_rst_ops: valid=%b a=%h lor=%h want 0", bus.vec_valid, bus.number_in_1_o, bus.lor_1_o); end
    checks++; if (bus.signature !== 32'h0 || bus.vec_count !== 16'h0 || bus.busy !== 1'b0) begin errors++; $display("FAIL mid_rst_state: sig=%h cnt=%0d busy=%b want 0 0 0", bus.signature, bus.vec_count, bus.busy); end
    #2; reset_n = 1'b1;
    repeat (3) @(posedge clock); #1;
    checks++; if (bus.vec_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mid_rst_idle: valid=%b busy=%b done=%b want 0 0 0", bus.vec_valid, bus.busy, bus.done); end
  endtask

  initial begin
    bus.start = 1'b0; bus.seed_load = 1'b0; bus.seed_in = 32'h0; bus.resp_in = 32'h0;
    test_reset();
    test_seed();
    test_seed_select();
    test_signature("sig_zero", 32'h0, 32'h0);
    test_signature("sig_one", 32'h1, 32'h8);
    test_signature("sig_fold", 32'h80000000, 32'h80E00009);
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
